// File: rtl/div_seq_8by4.sv
// div_seq_8by4: iterative restoring divider, 8-bit dividend by 4-bit divisor.
// One quotient bit per clock, MSB first. Eight RUN cycles per division, then
// a one-cycle DONE state in which a new start may be accepted back-to-back.
//
// Handshake: start is sampled on every rising edge but accepted only when the
// FSM is in IDLE or DONE; busy is high exactly while in RUN (start is ignored
// there); done is a one-cycle pulse that marks quotient/remainder/div_by_zero
// as holding a new result, which then holds until the next completion.
module div_seq_8by4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] dvd_sh;   // dividend, shifted left so the next bit is always [7]
   logic [3:0] dsr;      // captured divisor
   logic [4:0] prem;     // partial remainder, wide enough to keep the carry
   logic [2:0] cnt;      // iteration counter, 0..7
   logic [6:0] q_acc;    // quotient bits produced so far

   logic [4:0] shifted;
   logic [5:0] trial;
   logic       q_bit;

   assign dbg_state = state;

   // One restoring step: shift in the next dividend bit and try to subtract.
   always_comb begin
      shifted = 5'({prem, dvd_sh[7]});
      trial   = {1'b0, shifted} - {2'b00, dsr};
      q_bit   = ~trial[5];
   end

   // Control FSM plus datapath registers; all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= 8'h00;
         remainder   <= 4'h0;
         div_by_zero <= 1'b0;
         dvd_sh      <= 8'h00;
         dsr         <= 4'h0;
         prem        <= 5'h00;
         cnt         <= 3'd0;
         q_acc       <= 7'h00;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  dvd_sh <= dividend;
                  dsr    <= divisor;
                  prem   <= 5'h00;
                  cnt    <= 3'd0;
                  q_acc  <= 7'h00;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               dvd_sh <= {dvd_sh[6:0], 1'b0};
               prem   <= q_bit ? trial[4:0] : shifted;
               q_acc  <= {q_acc[5:0], q_bit};
               cnt    <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  // A zero divisor never borrows, so the quotient fills with
                  // ones and the remainder is the low dividend nibble.
                  quotient    <= {q_acc, q_bit};
                  remainder   <= q_bit ? trial[3:0] : shifted[3:0];
                  div_by_zero <= (dsr == 4'h0);
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_8by4.sv
// tb_div_seq_8by4: directed table-driven bench for div_seq_8by4 plus
// hand-written abort/ignore sequences and a back-to-back operand sweep.
module tb_div_seq_8by4;

   localparam logic [1:0] ST_IDLE = 2'd0;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic [1:0] dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   div_seq_8by4 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [12:0] exp_q[$];     // {quotient, remainder, div_by_zero}
   logic [12:0] prev_res;     // result the outputs must hold between completions
   int          n_cmp  = 0;
   int          n_fail = 0;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] out_word();
      return {quotient, remainder, div_by_zero};
   endfunction

   // ---------------- driver tasks ----------------
   // Issue one division from IDLE and follow it through to IDLE again.
   // inject_at > 0 drives a second start (50/3) in that RUN cycle.
   task automatic run_one(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic ez,
                          input int inject_at, input string tag);
      logic        bad;
      logic [12:0] exp;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back({eq, er, ez});
      bad = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = (c == inject_at);
         if (c == inject_at) begin
            dividend = 8'd50;
            divisor  = 4'd3;
         end
         if (busy !== 1'b1 || done !== 1'b0 || out_word() !== prev_res) bad = 1'b1;
      end
      start = 1'b0;
      check({tag, "_run_window"}, {31'd0, bad}, 32'd0);
      @(negedge clk);
      exp = exp_q.pop_front();
      check({tag, "_done"}, {30'd0, done, busy}, 32'd2);
      check({tag, "_result"}, {19'd0, out_word()}, {19'd0, exp});
      prev_res = exp;
      @(negedge clk);
      check({tag, "_after"}, {28'd0, done, busy, dbg_state}, {28'd0, 2'b00, ST_IDLE});
   endtask

   // ---------------- main test ----------------
   initial begin
      vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  z: 1'b0};
      vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  z: 1'b0};
      vecs[2] = '{a: 8'd13,  b: 4'd15, q: 8'd0,   r: 4'd13, z: 1'b0};
      vecs[3] = '{a: 8'd100, b: 4'd0,  q: 8'hFF,  r: 4'd4,  z: 1'b1};
      vecs[4] = '{a: 8'd50,  b: 4'd3,  q: 8'd16,  r: 4'd2,  z: 1'b0};
      vecs[5] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0,  z: 1'b0};
      vecs[6] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0,  z: 1'b0};
      vecs[7] = '{a: 8'd15,  b: 4'd4,  q: 8'd3,   r: 4'd3,  z: 1'b0};
      vecs[8] = '{a: 8'd0,   b: 4'd0,  q: 8'hFF,  r: 4'd0,  z: 1'b1};
      vecs[9] = '{a: 8'd128, b: 4'd9,  q: 8'd14,  r: 4'd2,  z: 1'b0};

      start    = 1'b0;
      dividend = 8'h00;
      divisor  = 4'h0;
      prev_res = 13'd0;
      rst_n    = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs", {19'd0, out_word()}, 32'd0);
      check("reset_ctrl", {28'd0, busy, done, dbg_state}, {28'd0, 2'b00, ST_IDLE});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 10; i++)
         run_one(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0,
                 $sformatf("vec%0d", i));

      // A start during RUN must not disturb the 200/7 in progress.
      run_one(8'd200, 8'd7, 8'd28, 4'd4, 1'b0, 3, "ignore_start");

      // Reset in the 4th RUN cycle: outputs clear at once, no done pulse.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {19'd0, out_word()}, 32'd0);
      check("abort_ctrl", {28'd0, busy, done, dbg_state}, {28'd0, 2'b00, ST_IDLE});
      begin
         logic saw_done;
         saw_done = 1'b0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
         end
         check("abort_no_done", {31'd0, saw_done}, 32'd0);
      end
      rst_n    = 1'b1;
      prev_res = 13'd0;
      run_one(8'd50, 4'd3, 8'd16, 4'd2, 1'b0, 0, "after_abort");

      // Back-to-back sweep of every operand pair, start issued in DONE.
      begin
         logic        bad;
         logic [12:0] exp;
         logic [7:0]  a;
         logic [3:0]  b;
         @(negedge clk);
         for (int p = 0; p < 4096; p++) begin
            a = p[11:4];
            b = p[3:0];
            start    = 1'b1;
            dividend = a;
            divisor  = b;
            if (b == 4'd0) exp_q.push_back({8'hFF, a[3:0], 1'b1});
            else           exp_q.push_back({8'(a / b), 4'(a % b), 1'b0});
            bad = 1'b0;
            for (int c = 1; c <= 8; c++) begin
               @(negedge clk);
               start = 1'b0;
               if (busy !== 1'b1 || done !== 1'b0 || out_word() !== prev_res) bad = 1'b1;
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            if (bad) check($sformatf("sweep_run_%0d_%0d", a, b), 32'd1, 32'd0);
            check($sformatf("sweep_done_%0d_%0d", a, b), {30'd0, done, busy}, 32'd2);
            check($sformatf("sweep_res_%0d_%0d", a, b), {19'd0, out_word()}, {19'd0, exp});
            prev_res = exp;
         end
         start = 1'b0;
         @(negedge clk);
         check("sweep_end_idle", {28'd0, done, busy, dbg_state}, {28'd0, 2'b00, ST_IDLE});
      end

      check("scoreboard_empty", exp_q.size(), 32'd0);

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq_8by4.md
DIV_SEQ_8BY4 -- requirements
Module: div_seq_8by4

Interface
REQ-001 Parameters: none; operand widths are fixed at 8-bit dividend and 4-bit divisor.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on the rising clk edge.
REQ-005 dividend  input  8  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  4  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  single-cycle pulse that marks new results valid.
REQ-009 quotient  output  8  unsigned quotient, registered.
REQ-010 remainder  output  4  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  high when the last completed division had divisor == 0; registered.

Function
REQ-012 The block SHALL be an iterative restoring divider producing one quotient bit per clock, MSB first.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 Transitions SHALL be as follows:
- IDLE -> RUN on start.
- RUN -> DONE after the 8th iteration.
- DONE -> RUN on start.
- DONE -> IDLE otherwise.
REQ-015 A start is accepted only in IDLE or DONE; at the accepting edge the block SHALL:
- capture dividend and divisor;
- clear the 5-bit partial remainder;
- clear the 3-bit iteration counter.
REQ-016 start asserted while in RUN SHALL be ignored: no operand capture and no effect on the division in progress.
REQ-017 Each RUN cycle SHALL perform one iteration:
- compute trial = {partial_rem[3:0], next dividend bit} - {1'b0, divisor};
- if trial is non-negative, partial_rem = trial and the quotient bit = 1;
- otherwise partial_rem = the shifted value unchanged (restore) and the quotient bit = 0.
REQ-018 The partial remainder SHALL be 5 bits wide, so the subtraction never loses a carry; the final remainder is partial_rem[3:0].
REQ-019 busy SHALL be 1 exactly in the RUN state, and 0 in IDLE and DONE.
REQ-020 Latency: if start is accepted at edge N, then quotient, remainder, div_by_zero and done=1 SHALL update at edge N+8 (after 8 RUN cycles).
REQ-021 done SHALL be high for exactly one cycle (the DONE state).
REQ-022 quotient, remainder and div_by_zero SHALL hold the previous result during RUN and update only at the completing edge; they then hold until the next completion or reset.
REQ-023 Divisor == 0 SHALL still take the same 8-cycle latency, with result:
- div_by_zero = 1;
- quotient = 8'hFF;
- remainder = dividend[3:0].
REQ-024 A nonzero divisor SHALL give:
- div_by_zero = 0;
- dividend == quotient*divisor + remainder;
- remainder < divisor.
REQ-025 Back-to-back operation: start in the DONE cycle SHALL be accepted, giving a throughput of one division per 9 cycles.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for a clock edge, force the following and hold them while low:
- state = IDLE;
- busy = 0, done = 0;
- quotient = 8'h00, remainder = 4'h0, div_by_zero = 0;
- internal registers cleared.
REQ-027 Reset during RUN SHALL abort the division with no done pulse; the first start after release SHALL behave as from power-up.
REQ-028 Release of rst_n SHALL be synchronised by the integrator; the block needs no first-cycle special case other than sampling start.

Verification
REQ-029 dividend=200, divisor=7, start pulse -> busy high for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
REQ-030 Two divisions: 255/1 -> quotient=255, remainder=0; then 13/15 -> quotient=0, remainder=13; both with div_by_zero=0 and 8-cycle latency.
REQ-031 100/0 -> done after 8 cycles with quotient=8'hFF, remainder=4, div_by_zero=1.
REQ-032 Start 200/7, then during RUN drive start with 50/3 -> second start ignored; result quotient=28, remainder=4; outputs hold the prior result until done.
REQ-033 Start 200/7, assert rst_n low at the 4th RUN cycle -> all outputs are 0 immediately, no done pulse; after release, 50/3 -> quotient=16, remainder=2.
REQ-034 Exhaustive sweep of all 4096 operand pairs, issued back-to-back with start in the DONE cycle -> every result matches the REQ-023/REQ-024 model, with one done pulse per 9 cycles.
